// File: rtl/tagged_flow_pkg.sv
// tagged_flow_pkg: default widths and din tag/payload split for the tagged flow FIFO bank
package tagged_flow_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_FLUX = 4;
  localparam int DEF_TAG_W = $clog2(DEF_FLUX);
  typedef struct packed {
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_DATA_W-1:0] data;
  } tagged_word_t;
  function automatic tagged_word_t split_din(input logic [DEF_TAG_W+DEF_DATA_W-1:0] din);
    return tagged_word_t'(din);
  endfunction
endpackage

// File: rtl/tagged_flow_fifo_bank_flow_fifo.sv
// flow_fifo: single-flow first-word-fall-through FIFO, storage not cleared by reset
module flow_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic wr_ok, rd_ok;
  assign full = count_q == DEPTH_C;
  assign empty = count_q == '0;
  assign count = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  // full is judged before the pop, so a write to a full FIFO is dropped even while it drains
  always_comb begin
    wr_ok = wr_en && !full;
    rd_ok = rd_en && !empty;
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  end
  // pointer and occupancy registers, discarded at once by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // storage array, written only on an accepted word
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/tagged_flow_fifo_bank.sv
// tagged_flow_fifo_bank: demux of a shared {tag,data} write bus into per-flow FWFT FIFOs; TAGGED_FIFO_OVF_CHECK_EN enables sticky overflow flags
module tagged_flow_fifo_bank
  import tagged_flow_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int FLUX   = DEF_FLUX,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = $clog2(FLUX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TAG_W+DATA_W-1:0]  din,
  input  logic                     write,
  output logic [FLUX-1:0]          full,
  input  logic [FLUX-1:0]          rd_en,
  output logic [FLUX*DATA_W-1:0]   dout,
  output logic [FLUX-1:0]          empty,
  output logic [FLUX-1:0]          ovf_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  logic [TAG_W-1:0] tag;
  logic [DATA_W-1:0] wdata;
  logic [FLUX-1:0] wr_en;
  logic [CW-1:0] cnt [FLUX];
  // route the write strobe to the flow named by the tag bits
  always_comb begin
    tag = din[TAG_W+DATA_W-1 -: TAG_W];
    wdata = din[DATA_W-1:0];
    wr_en = '0;
    wr_en[tag] = write;
  end
  for (genvar i = 0; i < FLUX; i++) begin : g_flow
    flow_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[i]),
      .wr_data (wdata),
      .rd_en   (rd_en[i]),
      .rd_data (dout[i*DATA_W +: DATA_W]),
      .full    (full[i]),
      .empty   (empty[i]),
      .count   (cnt[i])
    );
    a_cnt: assert property (@(posedge clk) disable iff (rst) cnt[i] <= DEPTH_C);
  end
`ifdef TAGGED_FIFO_OVF_CHECK_EN
  logic [FLUX-1:0] ovf_q, ovf_d;
  // a write aimed at a full flow latches that flow's error bit
  always_comb begin
    ovf_d = ovf_q;
    if (write && full[tag]) ovf_d[tag] = 1'b1;
  end
  // sticky error register, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= '0;
    else begin
      ovf_q <= ovf_d;
`ifndef SYNTHESIS
      if (write && full[tag]) $error("tagged_flow_fifo_bank: write dropped on full flow %0d", tag);
`endif
    end
  end
  assign ovf_err = ovf_q;
`else
  assign ovf_err = '0;
`endif
endmodule

// File: tb/tb_tagged_flow_fifo_bank.sv
// tb_tagged_flow_fifo_bank: scoreboard bench for the tagged flow FIFO bank
module tb_tagged_flow_fifo_bank;
  import tagged_flow_pkg::*;
  logic clk, rst, write;
  logic [9:0] din;
  logic [3:0] full, rd_en, empty, ovf_err;
  logic [31:0] dout;
  int checks = 0;
  int errors = 0;
  int mcnt [4];
  logic [7:0] q [4][$];
  logic [3:0] ovf_m;
  tagged_word_t w_in;
  bit done;
`ifdef TAGGED_FIFO_OVF_CHECK_EN
  localparam bit OVF_EXP = 1'b1;
`else
  localparam bit OVF_EXP = 1'b0;
`endif

  tagged_flow_fifo_bank dut (
    .clk(clk), .rst(rst), .din(din), .write(write), .full(full),
    .rd_en(rd_en), .dout(dout), .empty(empty), .ovf_err(ovf_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  assign w_in = split_din(din);

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] d);
    write = 1;
    din = d;
    step();
    write = 0;
  endtask

  task automatic pop(input int f);
    rd_en = 4'b0001 << f;
    step();
    rd_en = 0;
  endtask

  // reference model: occupancy, expected data queues and overflow flags
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mcnt[i] <= 0;
        q[i].delete();
      end
      ovf_m <= 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        mcnt[i] <= mcnt[i] + int'(write && w_in.tag == 2'(i) && mcnt[i] < 16) - int'(rd_en[i] && mcnt[i] > 0);
        if (write && w_in.tag == 2'(i) && mcnt[i] < 16) q[i].push_back(w_in.data);
        if (OVF_EXP && write && w_in.tag == 2'(i) && mcnt[i] == 16) ovf_m[i] <= 1'b1;
      end
    end
  end

  // monitor: flags every cycle, data on every pop the DUT will perform
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        chk(full[i] == (mcnt[i] == 16), $sformatf("full[%0d]", i), full[i], mcnt[i] == 16);
        chk(empty[i] == (mcnt[i] == 0), $sformatf("empty[%0d]", i), empty[i], mcnt[i] == 0);
        if (rd_en[i] && mcnt[i] > 0 && q[i].size() > 0) begin
          logic [7:0] e;
          e = q[i].pop_front();
          chk(dout[i*8 +: 8] == e, $sformatf("dout[%0d]", i), dout[i*8 +: 8], e);
        end else if (mcnt[i] == 0)
          chk(dout[i*8 +: 8] == 8'h00, $sformatf("dout_empty[%0d]", i), dout[i*8 +: 8], 0);
      end
      chk(ovf_err == ovf_m, "ovf_err", ovf_err, ovf_m);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; write = 0; din = 0; rd_en = 0; done = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk(full == 4'b0000, "idle_full", full, 0);
    chk(empty == 4'b1111, "idle_empty", empty, 4'hf);
    chk(dout == 32'h0, "idle_dout", dout, 0);
    chk(ovf_err == 4'b0000, "idle_ovf", ovf_err, 0);
    wr(10'h210); wr(10'h211); wr(10'h212);
    chk(empty == 4'b1011, "t2_empty", empty, 4'b1011);
    chk(dout == 32'h0010_0000, "t2_head", dout, 32'h0010_0000);
    repeat (3) pop(2);
    chk(empty == 4'b1111, "t2_drained", empty, 4'hf);
    for (int k = 0; k < 16; k++) wr({2'd1, 8'(8'h40 + k)});
    chk(full == 4'b0010, "t3_full", full, 4'b0010);
    wr(10'h1AA);
    chk(full == 4'b0010, "t3_full_after_drop", full, 4'b0010);
    chk(ovf_err[1] == OVF_EXP, "t3_ovf", ovf_err[1], OVF_EXP);
    repeat (16) pop(1);
    chk(empty[1] == 1'b1, "t3_drained", empty[1], 1);
    for (int k = 0; k < 16; k++) wr({2'd0, 8'(8'h80 + k)});
    chk(full == 4'b0001, "t4_full", full, 4'b0001);
    rd_en = 4'b0001; write = 1; din = 10'h0FF;
    step();
    rd_en = 0; write = 0;
    chk(full == 4'b0000, "t4_full_after_rw", full, 0);
    repeat (15) pop(0);
    chk(empty == 4'b1111, "t4_drained_15", empty, 4'hf);
    fork
      begin
        for (int b = 0; b < 92; b++) begin
          int f;
          f = b % 4;
          for (int k = 0; k < 23; k++) begin
            int stall, idx;
            idx = (b / 4) * 23 + k;
            stall = 0;
            while (full[f] && stall < 500) begin
              write = 0;
              step();
              stall++;
            end
            if (stall >= 500) chk(0, "t5_producer_stall", stall, 500);
            write = 1;
            din = {2'(f), 8'(idx * 5 + f * 3)};
            step();
          end
        end
        write = 0;
        done = 1;
      end
      begin
        while (!done) begin
          rd_en = 4'($urandom);
          step();
        end
        rd_en = 0;
      end
    join
    begin
      int n;
      n = 0;
      rd_en = 4'b1111;
      while ((mcnt[0] + mcnt[1] + mcnt[2] + mcnt[3]) > 0 && n < 100) begin
        step();
        n++;
      end
      rd_en = 0;
      chk(n < 100, "t5_drain_budget", n, 100);
      step();
      chk(empty == 4'b1111, "t5_all_empty", empty, 4'hf);
    end
    for (int k = 0; k < 5; k++) wr({2'd3, 8'(8'hC0 + k)});
    chk(empty == 4'b0111, "t6_loaded", empty, 4'b0111);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk(empty == 4'b1111, "t6_async_empty", empty, 4'hf);
    chk(full == 4'b0000, "t6_async_full", full, 0);
    chk(dout == 32'h0, "t6_async_dout", dout, 0);
    chk(ovf_err == 4'b0000, "t6_async_ovf", ovf_err, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    wr(10'h3E1); wr(10'h3E2);
    chk(dout[31:24] == 8'hE1, "t6_head", dout[31:24], 8'hE1);
    pop(3); pop(3);
    chk(empty == 4'b1111, "t6_drained", empty, 4'hf);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tagged_flow_fifo_bank.md
Name: tagged_flow_fifo_bank

Overview:
- Receiving end of the tagged multi-flow write interface used by the multi-stream filter (`top_ms`).
- The producer drives one shared `din = {tag, data}` plus `write`, and watches a per-flow `full` vector.
- This block demultiplexes each accepted word into one of FLUX independent per-flow FIFOs.
- Each FIFO exposes a first-word-fall-through read port to the per-flow consumer (filter front end).

Parameters:
- DEPTH, 16, entries per flow FIFO; power of two, >= 2.
- FLUX, 4, number of flows; power of two, >= 2.
- DATA_W, 8, payload width.
- TAG_W, $clog2(FLUX), tag width (2 at FLUX=4).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  TAG_W+DATA_W  `{tag, data}`; tag occupies the MSBs (bits 9:8 at defaults).
- write  in  1  write strobe, sampled on the rising edge of clk.
- full  out  FLUX  per-flow full flag; bit i refers to flow i.
- rd_en  in  FLUX  per-flow pop request.
- dout  out  FLUX*DATA_W  flow i occupies bits [i*DATA_W +: DATA_W].
- empty  out  FLUX  per-flow empty flag.
- ovf_err  out  FLUX  sticky overflow error (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst=1):
  - all read/write pointers and counts go to 0;
  - full = 0, empty = all ones, ovf_err = 0, dout = 0.
  - Reset mid-operation discards all contents immediately; storage RAM is not cleared.
- Write acceptance:
  - On a rising edge with write=1, let t = din[TAG_W+DATA_W-1 -: TAG_W].
  - If full[t]=0, data is stored at wr_ptr[t], wr_ptr[t] increments (wraps mod DEPTH) and count[t] increments.
  - If full[t]=1, the word is dropped and no state changes.
- Per-flow count, width $clog2(DEPTH)+1:
  - full[i] = (count[i]==DEPTH);
  - empty[i] = (count[i]==0).
  - Both flags are decoded from registers, so they are glitch-free and change only after a clock edge.
- Latency:
  - A word written at edge N gives empty=0 and a valid dout after edge N.
  - It is poppable at edge N+1.
  - There is no same-cycle write-to-read bypass.
- Read:
  - dout slice i = mem_i[rd_ptr[i]] when empty[i]=0, forced to 0 when empty[i]=1.
  - On an edge with rd_en[i]=1 and empty[i]=0, rd_ptr[i] increments (wraps) and count[i] decrements.
  - rd_en[i] while empty[i]=1 is ignored.
- Simultaneous write and read on the same flow:
  - Not full and not empty: both happen and count is unchanged.
  - Full: the pop happens and the write is dropped (full is evaluated before the pop).
  - Empty: the write happens and the pop is ignored.
- Flows are fully independent; activity on one flow never stalls another.
- Only one write per cycle, since the bus is shared.

Optional Feature:
- Macro: TAGGED_FIFO_OVF_CHECK_EN.
- Defined: a dropped write (write=1 with full[t]=1) sets ovf_err[t].
  - ovf_err is sticky until rst.
  - Simulation builds also issue $error with the flow index.
- Undefined: ovf_err is tied to 0 and dropped writes are silent.

Decomposition:
- Package `tagged_flow_pkg` holds:
  - the default DATA_W, TAG_W and FLUX constants;
  - a function that extracts the tag and the payload from din.
- One sub-module, `flow_fifo`:
  - single-flow FWFT FIFO with DEPTH/DATA_W parameters;
  - ports: wr_en, wr_data, rd_en, rd_data, full, empty, count.
  - Instantiated FLUX times by a generate loop.
- The top level holds only the tag decode and the overflow logic.

Test Plan:
1. Reset, then check idle state.
   - Stimulus: release rst.
   - Required: full=4'b0000, empty=4'b1111, dout=0, ovf_err=0.
2. Single flow in order.
   - Stimulus: write 0x210, 0x211, 0x212 (flow 2, data 0x10..0x12), then pulse rd_en[2] three times.
   - Required: dout slice 2 reads 0x10, 0x11, 0x12 in order; empty[2] returns to 1; the other flows are untouched.
3. Fill and overflow.
   - Stimulus: write 16 words to flow 1, then write 0x1AA.
   - Required: full[1]=1 after the 16th edge; 0x1AA is dropped; ovf_err[1]=1 when the macro is defined, 0 otherwise; draining returns the 16 original words.
4. Full plus simultaneous read and write.
   - Stimulus: with flow 0 full, set rd_en[0]=1 and write 0x0FF on the same edge.
   - Required: one pop occurs, count becomes 15, 0xFF is not stored.
5. Round-robin interleave like the filter feeder.
   - Stimulus: blocks of 23 words rotating over flows 0..3, 529 words per flow, with a random consumer per flow.
   - Required: every flow's output sequence equals its input sequence; no word is lost while the producer honours full.
6. Reset mid-stream.
   - Stimulus: assert rst while flow 3 holds 5 words.
   - Required: empty[3]=1 immediately (asynchronous); subsequent writes start at pointer 0.
